// File: rtl/pc_fetch_sequencer_pkg.sv
// Shared definitions for the LEGv8 multicycle fetch/branch controller.
//   state_t   - controller state encoding (IDLE, FETCH, EXEC, HALT, FAULT)
//   PC_STEP   - sequential PC increment (one 32-bit instruction word)
//   BR_SHIFT  - word-offset to byte-offset shift applied to branch immediates
package pc_fetch_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_HALT  = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    localparam logic [63:0] PC_STEP  = 64'd4;
    localparam int          BR_SHIFT = 2;

endpackage

// File: rtl/pc_fetch_sequencer_next_pc_calc.sv
// next_pc_calc: combinational next-PC rule shared with the single-cycle datapath.
//   CurrentPC     in   64  architectural PC
//   SignExtImm64  in   64  sign-extended word offset
//   Branch        in   1   conditional branch (CBZ)
//   ALUZero       in   1   ALU zero flag
//   Uncondbranch  in   1   unconditional branch (B)
//   NextPC        out  64  CurrentPC + 4, or CurrentPC + (SignExtImm64 << 2) when taken
module next_pc_calc
    import pc_fetch_sequencer_pkg::*;
(
    input  logic [63:0] CurrentPC,
    input  logic [63:0] SignExtImm64,
    input  logic        Branch,
    input  logic        ALUZero,
    input  logic        Uncondbranch,
    output logic [63:0] NextPC
);

    logic        take;
    logic [63:0] br_offset;

    // NOTE: every signal assigned in always_comb gets a value on every path,
    // otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        take      = Uncondbranch | (Branch & ALUZero);
        // Bits [63:62] of the immediate fall off the top; the sum wraps mod 2^64.
        br_offset = SignExtImm64 << BR_SHIFT;
        NextPC    = take ? (CurrentPC + br_offset) : (CurrentPC + PC_STEP);
    end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: multicycle fetch/branch controller owning the LEGv8 PC.
//   CLK           in   1      clock, rising edge
//   Reset         in   1      synchronous reset, active-high
//   Start         in   1      leave IDLE and begin fetching at CurrentPC
//   IMemReq       out  1      fetch request, address = CurrentPC
//   IMemAck       in   1      fetch complete, IMemData valid
//   IMemData      in   32     fetched instruction word
//   Instruction   out  32     latched instruction
//   InstrValid    out  1      one-cycle pulse when Instruction is newly latched
//   ExecDone      in   1      execute finished, branch inputs valid
//   Branch        in   1      conditional branch (CBZ)
//   ALUZero       in   1      ALU zero flag
//   Uncondbranch  in   1      unconditional branch (B)
//   SignExtImm64  in   64     sign-extended word offset
//   Halt          in   1      with ExecDone: stop after this instruction
//   CurrentPC     out  64     architectural PC
//   RetiredCount  out  CNT_W  completed instructions, wraps
//   Busy          out  1      high in FETCH or EXEC
//   Fault         out  1      fetch timeout, sticky until Reset
module pc_fetch_sequencer
    import pc_fetch_sequencer_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          MAX_WAIT = 16,
    parameter int          CNT_W    = 32
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Start,
    output logic             IMemReq,
    input  logic             IMemAck,
    input  logic [31:0]      IMemData,
    output logic [31:0]      Instruction,
    output logic             InstrValid,
    input  logic             ExecDone,
    input  logic             Branch,
    input  logic             ALUZero,
    input  logic             Uncondbranch,
    input  logic [63:0]      SignExtImm64,
    input  logic             Halt,
    output logic [63:0]      CurrentPC,
    output logic [CNT_W-1:0] RetiredCount,
    output logic             Busy,
    output logic             Fault
);

    localparam int                WAIT_W    = $clog2(MAX_WAIT + 1);
    // Counter value seen on the MAX_WAITth consecutive FETCH cycle without ack.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [63:0]       next_pc;

    next_pc_calc u_next_pc_calc (
        .CurrentPC    (CurrentPC),
        .SignExtImm64 (SignExtImm64),
        .Branch       (Branch),
        .ALUZero      (ALUZero),
        .Uncondbranch (Uncondbranch),
        .NextPC       (next_pc)
    );

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge CLK) begin
        // NOTE: reset is synchronous and clears every register here; there is
        // no memory array, so nothing is left to come up undefined.
        if (Reset) begin
            state        <= ST_IDLE;
            CurrentPC    <= RESET_PC;
            IMemReq      <= 1'b0;
            Instruction  <= '0;
            InstrValid   <= 1'b0;
            RetiredCount <= '0;
            Busy         <= 1'b0;
            Fault        <= 1'b0;
            wait_cnt     <= '0;
        end else begin
            // Pulse output: only the ack cycle below raises it for one cycle.
            InstrValid <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (Start) begin
                        state    <= ST_FETCH;
                        IMemReq  <= 1'b1;
                        Busy     <= 1'b1;
                        wait_cnt <= '0;
                    end
                end

                ST_FETCH: begin
                    // Ack is checked first, so an ack on the last allowed
                    // cycle is accepted rather than faulting.
                    if (IMemAck) begin
                        Instruction <= IMemData;
                        InstrValid  <= 1'b1;
                        IMemReq     <= 1'b0;
                        state       <= ST_EXEC;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state   <= ST_FAULT;
                        Fault   <= 1'b1;
                        IMemReq <= 1'b0;
                        Busy    <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end

                ST_EXEC: begin
                    if (ExecDone) begin
                        RetiredCount <= RetiredCount + CNT_W'(1);
                        if (Halt) begin
                            // The halting instruction retires but leaves PC on itself.
                            state <= ST_HALT;
                            Busy  <= 1'b0;
                        end else begin
                            CurrentPC <= next_pc;
                            state     <= ST_FETCH;
                            IMemReq   <= 1'b1;
                            wait_cnt  <= '0;
                        end
                    end
                end

                // HALT and FAULT are terminal; only Reset leaves them.
                ST_HALT, ST_FAULT: ;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Self-checking bench for pc_fetch_sequencer with directed vectors.
// RESET_PC is set to 0x10 so each scenario starts from the PCs it talks about.
module tb_pc_fetch_sequencer;

    localparam logic [63:0] RST_PC = 64'h10;

    logic        CLK = 1'b0;
    logic        Reset, Start, IMemAck, ExecDone, Branch, ALUZero, Uncondbranch, Halt;
    logic [31:0] IMemData;
    logic [63:0] SignExtImm64;
    logic        IMemReq, InstrValid, Busy, Fault;
    logic [31:0] Instruction;
    logic [63:0] CurrentPC;
    logic [31:0] RetiredCount;

    int n_checks = 0;
    int n_fail   = 0;

    pc_fetch_sequencer #(
        .RESET_PC (RST_PC),
        .MAX_WAIT (16),
        .CNT_W    (32)
    ) dut (
        .CLK          (CLK),
        .Reset        (Reset),
        .Start        (Start),
        .IMemReq      (IMemReq),
        .IMemAck      (IMemAck),
        .IMemData     (IMemData),
        .Instruction  (Instruction),
        .InstrValid   (InstrValid),
        .ExecDone     (ExecDone),
        .Branch       (Branch),
        .ALUZero      (ALUZero),
        .Uncondbranch (Uncondbranch),
        .SignExtImm64 (SignExtImm64),
        .Halt         (Halt),
        .CurrentPC    (CurrentPC),
        .RetiredCount (RetiredCount),
        .Busy         (Busy),
        .Fault        (Fault)
    );

    always #5 CLK = ~CLK;

    // Advance past one rising edge; outputs are observed 1ns after it.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        Start = 0; IMemAck = 0; ExecDone = 0; Branch = 0; ALUZero = 0;
        Uncondbranch = 0; Halt = 0; IMemData = '0; SignExtImm64 = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        Reset = 1;
        tick();
        Reset = 0;
    endtask

    task automatic begin_fetch(input string tag);
        Start = 1;
        tick();
        Start = 0;
        n_checks++;
        if (IMemReq !== 1'b1) begin n_fail++; $display("FAIL %s start_req: IMemReq got %b want 1", tag, IMemReq); end
        n_checks++;
        if (Busy !== 1'b1) begin n_fail++; $display("FAIL %s start_busy: Busy got %b want 1", tag, Busy); end
    endtask

    // Wait 'misses' FETCH cycles without ack, then ack with 'data'.
    task automatic fetch(input string tag, input int misses, input logic [31:0] data);
        for (int i = 0; i < misses; i++) tick();
        n_checks++;
        if (IMemReq !== 1'b1) begin n_fail++; $display("FAIL %s req_held: IMemReq got %b want 1", tag, IMemReq); end
        IMemAck  = 1;
        IMemData = data;
        tick();
        IMemAck  = 0;
        IMemData = '0;
        n_checks++;
        if (InstrValid !== 1'b1) begin n_fail++; $display("FAIL %s valid_hi: InstrValid got %b want 1", tag, InstrValid); end
        n_checks++;
        if (Instruction !== data) begin n_fail++; $display("FAIL %s instr: got %h want %h", tag, Instruction, data); end
        n_checks++;
        if (IMemReq !== 1'b0 || Fault !== 1'b0) begin
            n_fail++; $display("FAIL %s req_drop: IMemReq=%b Fault=%b want 0 0", tag, IMemReq, Fault);
        end
        tick();
        n_checks++;
        if (InstrValid !== 1'b0) begin n_fail++; $display("FAIL %s valid_lo: InstrValid got %b want 0", tag, InstrValid); end
    endtask

    // One ExecDone cycle with the given branch inputs.
    task automatic exec(input string tag, input logic br, input logic zero, input logic unc,
                        input logic [63:0] imm, input logic halt,
                        input logic [63:0] exp_pc, input logic [31:0] exp_ret);
        ExecDone = 1; Branch = br; ALUZero = zero; Uncondbranch = unc; SignExtImm64 = imm; Halt = halt;
        tick();
        clear_inputs();
        n_checks++;
        if (CurrentPC !== exp_pc) begin n_fail++; $display("FAIL %s pc: got %h want %h", tag, CurrentPC, exp_pc); end
        n_checks++;
        if (RetiredCount !== exp_ret) begin n_fail++; $display("FAIL %s retired: got %0d want %0d", tag, RetiredCount, exp_ret); end
        n_checks++;
        if (IMemReq !== !halt || Busy !== !halt) begin
            n_fail++; $display("FAIL %s next_state: IMemReq=%b Busy=%b want %b %b", tag, IMemReq, Busy, !halt, !halt);
        end
    endtask

    task automatic check_idle_reset(input string tag);
        n_checks++;
        if (CurrentPC !== RST_PC) begin n_fail++; $display("FAIL %s pc: got %h want %h", tag, CurrentPC, RST_PC); end
        n_checks++;
        if (IMemReq !== 1'b0 || Busy !== 1'b0 || Fault !== 1'b0 || InstrValid !== 1'b0) begin
            n_fail++; $display("FAIL %s flags: IMemReq=%b Busy=%b Fault=%b InstrValid=%b want 0 0 0 0",
                               tag, IMemReq, Busy, Fault, InstrValid);
        end
        n_checks++;
        if (Instruction !== 32'h0 || RetiredCount !== 32'h0) begin
            n_fail++; $display("FAIL %s regs: Instruction=%h RetiredCount=%0d want 0 0", tag, Instruction, RetiredCount);
        end
    endtask

    task automatic test_reset();
        // Reset asserted together with every other input must still win.
        Reset = 1; Start = 1; IMemAck = 1; ExecDone = 1; IMemData = 32'hDEAD_BEEF;
        tick();
        tick();
        Reset = 0;
        clear_inputs();
        check_idle_reset("reset");
        tick();
        check_idle_reset("reset_idle_hold");
    endtask

    task automatic test_sequential();
        do_reset();
        begin_fetch("seq");
        fetch("seq", 2, 32'h8B02_0020);
        exec("seq", 0, 0, 0, 64'h0, 0, 64'h14, 32'd1);
    endtask

    task automatic test_branches();
        do_reset();
        begin_fetch("cbz_taken");
        fetch("cbz_taken", 0, 32'hB400_0040);
        exec("cbz_taken", 1, 1, 0, 64'd2, 0, 64'h18, 32'd1);

        do_reset();
        begin_fetch("cbz_not");
        fetch("cbz_not", 1, 32'hB400_0060);
        exec("cbz_not", 1, 0, 0, 64'd3, 0, 64'h14, 32'd1);

        do_reset();
        begin_fetch("b_first");
        fetch("b_first", 0, 32'h1400_0004);
        exec("b_first", 0, 0, 1, 64'd4, 0, 64'h20, 32'd1);
        fetch("b_second", 3, 32'h1400_0004);
        // Uncondbranch overrides a not-taken CBZ.
        exec("b_second", 1, 0, 1, 64'd4, 0, 64'h30, 32'd2);
    endtask

    task automatic test_negative_and_wrap();
        do_reset();
        begin_fetch("neg");
        fetch("neg", 0, 32'h1400_000C);
        exec("neg_to_40", 0, 0, 1, 64'd12, 0, 64'h40, 32'd1);
        fetch("neg", 0, 32'h17FF_FFFE);
        exec("neg_back", 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFE, 0, 64'h38, 32'd2);

        do_reset();
        begin_fetch("wrap");
        fetch("wrap", 0, 32'h17FF_FFFB);
        // 0x10 + (-5 << 2) = 0xFFFF_FFFF_FFFF_FFFC
        exec("wrap_to_top", 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFB, 0, 64'hFFFF_FFFF_FFFF_FFFC, 32'd1);
        fetch("wrap", 0, 32'h8B00_0000);
        exec("wrap_to_zero", 0, 0, 0, 64'h0, 0, 64'h0, 32'd2);

        // Bit 62 of the immediate is shifted out: offset becomes 4.
        do_reset();
        begin_fetch("imm_top");
        fetch("imm_top", 0, 32'h1400_0001);
        exec("imm_top_bits", 0, 0, 1, 64'h4000_0000_0000_0001, 0, 64'h14, 32'd1);
    endtask

    task automatic test_timeout();
        // Ack on the 16th FETCH cycle is still accepted.
        do_reset();
        begin_fetch("ack_last");
        fetch("ack_last", 15, 32'hCAFE_0001);

        do_reset();
        begin_fetch("timeout");
        for (int i = 0; i < 15; i++) tick();
        n_checks++;
        if (Fault !== 1'b0 || IMemReq !== 1'b1) begin
            n_fail++; $display("FAIL timeout_before: Fault=%b IMemReq=%b want 0 1", Fault, IMemReq);
        end
        tick();
        n_checks++;
        if (Fault !== 1'b1 || IMemReq !== 1'b0 || Busy !== 1'b0) begin
            n_fail++; $display("FAIL timeout_fault: Fault=%b IMemReq=%b Busy=%b want 1 0 0", Fault, IMemReq, Busy);
        end
        IMemAck = 1; IMemData = 32'h1234_5678; Start = 1;
        tick();
        clear_inputs();
        tick();
        tick();
        n_checks++;
        if (Fault !== 1'b1 || IMemReq !== 1'b0 || InstrValid !== 1'b0 || Instruction !== 32'h0) begin
            n_fail++; $display("FAIL timeout_late_ack: Fault=%b IMemReq=%b InstrValid=%b Instruction=%h want 1 0 0 0",
                               Fault, IMemReq, InstrValid, Instruction);
        end
    endtask

    task automatic test_halt();
        do_reset();
        begin_fetch("halt");
        fetch("halt", 0, 32'h1400_0005);
        exec("halt_to_24", 0, 0, 1, 64'd5, 0, 64'h24, 32'd1);
        fetch("halt", 1, 32'hD440_0000);
        exec("halt_stop", 0, 0, 1, 64'd8, 1, 64'h24, 32'd2);
        Start = 1; ExecDone = 1; IMemAck = 1;
        tick();
        clear_inputs();
        tick();
        n_checks++;
        if (IMemReq !== 1'b0 || Busy !== 1'b0 || CurrentPC !== 64'h24 || RetiredCount !== 32'd2) begin
            n_fail++; $display("FAIL halt_terminal: IMemReq=%b Busy=%b PC=%h Retired=%0d want 0 0 24 2",
                               IMemReq, Busy, CurrentPC, RetiredCount);
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        begin_fetch("rst_fetch");
        tick();
        Reset = 1;
        tick();
        Reset = 0;
        check_idle_reset("rst_mid_fetch");

        // Retire one instruction, then reset on the InstrValid cycle of the next.
        begin_fetch("rst_exec");
        fetch("rst_exec", 0, 32'h8B01_0000);
        exec("rst_exec_pre", 0, 0, 0, 64'h0, 0, 64'h14, 32'd1);
        IMemAck = 1; IMemData = 32'hAAAA_5555;
        tick();
        IMemAck = 0;
        Reset = 1; ExecDone = 1;
        tick();
        Reset = 0; ExecDone = 0;
        check_idle_reset("rst_mid_exec");

        // Stray handshakes in IDLE.
        IMemAck = 1; IMemData = 32'h5555_AAAA; ExecDone = 1; Uncondbranch = 1; SignExtImm64 = 64'd8;
        tick();
        clear_inputs();
        tick();
        check_idle_reset("idle_stray");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        Reset = 1;
        test_reset();
        test_sequential();
        test_branches();
        test_negative_and_wrap();
        test_timeout();
        test_halt();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
